// File: rtl/mips_hazard_unit.sv
// Hazard, forwarding and memory-wait controller for a 5-stage MIPS pipeline.
// Produces pipeline enables, bubbles, flushes, forwarding selects and saturating perf counters.
module mips_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_LAT    = 0,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_branch,
    input  logic                  pc_src_taken,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic                  mem_access,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  perf_clr,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_write,
    output logic                  exmem_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  memwb_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  fwd_id_a,
    output logic                  fwd_id_b,
    output logic                  mem_busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WCNT_W      = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int WCNT_INIT_I = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
    localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WCNT_INIT_I);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_stall;
    logic               lu_stall, br_stall, br_ex_hit, br_mem_hit;

    // The access that enters WAIT is itself the first stall cycle, so MEM_LAT-1 remain.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_access && (MEM_LAT > 0)) begin
                    mem_stall = 1'b1;
                    wcnt_d    = WCNT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q != '0) begin
                    mem_stall = 1'b1;
                    wcnt_d    = wcnt_q - WCNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lu_stall   = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
        br_ex_hit  = ex_reg_write && (ex_rd != '0) &&
                     ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
        br_mem_hit = mem_mem_read && (mem_rd != '0) &&
                     ((id_uses_rs && (mem_rd == id_rs)) || (id_uses_rt && (mem_rd == id_rt)));
        br_stall   = id_branch && (br_ex_hit || br_mem_hit);
    end

    // Reset forces the pipeline into a free-running, no-forwarding state.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        fwd_id_a     = 1'b0;
        fwd_id_b     = 1'b0;
        mem_busy     = 1'b0;
        if (rst) begin
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))      fwd_a = 2'b10;
            else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))    fwd_a = 2'b01;
            if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt))      fwd_b = 2'b10;
            else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt))    fwd_b = 2'b01;
            fwd_id_a = mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == id_rs);
            fwd_id_b = mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == id_rt);
            mem_busy = mem_stall;
            if (mem_stall) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
            end else if (lu_stall || br_stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                ifid_flush = pc_src_taken;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_write && (stall_cnt_q != CNT_MAX))  stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (ifid_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
Parametrised hazard, forwarding and memory-wait controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Sits beside the pipelined Controller.
- Drives the pipeline-register write enables, bubbles and flushes, plus EX/ID forwarding selects.
- Beyond plain load-use detection, it adds configurable multi-cycle data-memory latency, ID-stage branch hazards and saturating performance counters.

Parameters:
REG_ADDR_W, 5, register-specifier width.
MEM_LAT, 0, extra wait cycles per data-memory access (0 = single-cycle memory).
CNT_W, 32, width of each performance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
id_rs, id_rt  in  REG_ADDR_W  source registers of the ID instruction.
id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs/rt.
id_branch  in  1  ID instruction is a branch compared in ID.
pc_src_taken  in  1  branch/jump taken, resolved in ID.
ex_rs, ex_rt  in  REG_ADDR_W  sources of the EX instruction.
ex_rd  in  REG_ADDR_W  destination of the EX instruction.
ex_reg_write, ex_mem_read  in  1  EX writes a register / EX is a load.
mem_rd  in  REG_ADDR_W  destination in MEM.
mem_reg_write, mem_mem_read, mem_access  in  1  MEM control (mem_access = read or write).
wb_rd  in  REG_ADDR_W  destination in WB.
wb_reg_write  in  1  WB writes a register.
perf_clr  in  1  synchronous counter clear.
pc_write, ifid_write, idex_write, exmem_write  out  1  register enables.
ifid_flush, idex_bubble, memwb_bubble  out  1  insert NOP into IF/ID, ID/EX, MEM/WB.
fwd_a, fwd_b  out  2  EX operand source: 00 regfile/ID/EX, 01 WB, 10 MEM.
fwd_id_a, fwd_id_b  out  1  ID branch-compare operand from MEM.
mem_busy  out  1  memory wait in progress.
stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (rst=0 at an edge):
  - FSM goes to IDLE; wait counter and both perf counters go to 0.
  - While rst=0, all enables read 1; flush, bubble, mem_busy and forwarding outputs read 0.
- Destination register 0 never matches: no hazard and no forward on rd=0.
- Forwarding (combinational):
  - fwd_a=10 if mem_reg_write and mem_rd==ex_rs; otherwise 01 if wb_reg_write and wb_rd==ex_rs; otherwise 00. MEM wins over WB.
  - fwd_b uses the same rule on ex_rt.
  - fwd_id_a/b=1 if mem_reg_write, !mem_mem_read and mem_rd matches id_rs/id_rt.
- Memory-wait FSM, states IDLE and WAIT, with counter wcnt of width clog2(MEM_LAT+1):
  - IDLE, mem_access=1, MEM_LAT>0: mem_stall=1, wcnt<=MEM_LAT-1, go to WAIT.
  - WAIT, wcnt!=0: mem_stall=1, wcnt decrements.
  - WAIT, wcnt==0: mem_stall=0, the instruction advances, go to IDLE.
  - Net result: exactly MEM_LAT stall cycles per access.
  - Back-to-back accesses each re-enter WAIT.
  - MEM_LAT=0: FSM stays in IDLE permanently.
  - mem_busy=mem_stall.
- Load-use stall (lu_stall): ex_mem_read and ex_rd!=0 and ((id_uses_rs and ex_rd==id_rs) or (id_uses_rt and ex_rd==id_rt)).
- Branch stall (br_stall): id_branch and a needed source matches either:
  - ex_rd with ex_reg_write (1 cycle), or
  - mem_rd with mem_mem_read (load in MEM, 1 cycle).
- Priority: mem_stall > (lu_stall | br_stall) > flush.
  - mem_stall: pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, ifid_flush=0, idex_bubble=0.
  - lu/br stall: pc_write=ifid_write=0, idex_bubble=1, others at defaults.
  - Otherwise: ifid_flush=pc_src_taken.
  - A taken branch held by any stall is not flushed until the stall clears.
- Counters, registered:
  - stall_cnt increments on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both saturate at 2^CNT_W-1.
  - perf_clr=1 clears both and overrides an increment in the same cycle.
- Reset mid-WAIT: FSM returns to IDLE on the next edge and the pending wait is abandoned.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> pc_write=0, ifid_write=0, idex_bubble=1 for one cycle; stall_cnt 0->1.
- Forward priority: mem_rd=wb_rd=ex_rs=9, both reg_write=1 -> fwd_a=10. Repeat with mem_reg_write=0 -> fwd_a=01. Repeat with ex_rs=0 -> fwd_a=00.
- Memory wait: MEM_LAT=3, mem_access=1 held -> mem_busy=1 for exactly 3 cycles, memwb_bubble=1 and all enables 0 during them, released on the 4th cycle; stall_cnt=3.
- Branch in ID: pc_src_taken=1 with no hazards -> ifid_flush=1, flush_cnt=1. Same with id_branch=1 and ex_rd==id_rs, ex_reg_write=1 -> one stall cycle first, then the flush.
- Saturation and clear: CNT_W=4, force 20 stall cycles -> stall_cnt=15. Assert perf_clr together with a stall -> stall_cnt=0.
- Reset during WAIT: MEM_LAT=3, drive rst=0 in the 2nd wait cycle -> mem_busy=0 after the edge, counters 0, and a fresh access restarts the full 3-cycle wait.
